// File: rtl/eth_pkg.sv
// Shared Ethernet receive-path definitions: FCS size, EtherType codes and the
// dispatcher state encoding.
package eth_pkg;

  localparam int          ETH_FCS_BYTES = 4;
  localparam logic [15:0] ETYPE_IPV4    = 16'h0800;
  localparam logic [15:0] ETYPE_ARP     = 16'h0806;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARP  = 2'd1,
    ST_IP   = 2'd2,
    ST_DROP = 2'd3
  } rx_disp_state_t;

endpackage

// File: rtl/byte_delay.sv
// Byte shift register. Entry 0 is the newest byte. o_dout presents the oldest
// held byte, o_count gives the occupancy, and i_flush empties the line.
module byte_delay #(
  parameter int DEPTH = 5,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [7:0]    i_din,
  output logic [7:0]    o_dout,
  output logic [CW-1:0] o_count
);

  logic [7:0]    r_mem [DEPTH];
  logic [CW-1:0] r_count;

  // Shift a new byte in at the head of the line.
  // NOTE: the data entries carry no reset; r_count alone marks which entries hold real bytes.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
    end
  end

  // Track occupancy. A simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else if (i_push && !i_pop && r_count != CW'(DEPTH)) begin
      r_count <= r_count + 1'b1;
    end else if (i_pop && !i_push && r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Select the oldest valid entry.
  always_comb begin
    o_dout = r_mem[0];
    for (int i = 1; i < DEPTH; i++) begin
      if (r_count == CW'(i + 1)) o_dout = r_mem[i];
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/eth_rx_dispatch.sv
// Receive-side frame dispatcher. It routes each accepted frame payload to the
// ARP or IP engine, strips the FCS through a 5-byte delay line, reports length
// and source MAC, and keeps saturating outcome counters.
module eth_rx_dispatch
  import eth_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rxd,
  input  logic             busy,
  input  logic             crc_err,
  input  logic             arp_decode_valid,
  input  logic             ip_valid,
  input  logic [47:0]      sa,
  input  logic             arp_en,
  input  logic             ip_en,
  input  logic             stat_clr,
  output logic [7:0]       arp_data,
  output logic [7:0]       ip_data,
  output logic             arp_valid,
  output logic             ip_valid_o,
  output logic             arp_last,
  output logic             ip_last,
  output logic             arp_err,
  output logic             ip_err,
  output logic [LEN_W-1:0] frame_len,
  output logic [47:0]      frame_sa,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_crc,
  output logic [CNT_W-1:0] cnt_drop
);

  // One byte more than the FCS must be held before a byte is known to be payload.
  localparam int DEPTH = ETH_FCS_BYTES + 1;
  localparam int DCW   = $clog2(DEPTH + 1);
  localparam int CAP_W = LEN_W + 1;

  rx_disp_state_t   r_state, w_state_nxt;
  logic             r_flag_q;
  logic             r_crc_base;
  logic [CAP_W-1:0] r_cap;
  logic [7:0]       r_data;
  logic             r_arp_v, r_ip_v, r_last, r_err;
  logic [LEN_W-1:0] r_len;
  logic [47:0]      r_sa;
  logic [CNT_W-1:0] r_cnt_ok, r_cnt_crc, r_cnt_drop;

  logic             w_any_flag, w_sel_flag, w_err;
  logic             w_push, w_pop, w_flush, w_start, w_emit, w_emit_last;
  logic             w_inc_ok, w_inc_crc, w_inc_drop;
  logic [7:0]       w_line_dout;
  logic [DCW-1:0]   w_line_count;
  logic [CAP_W-1:0] w_len_full;
  logic [LEN_W-1:0] w_len_sat;

  assign w_any_flag = arp_decode_valid | ip_valid;
  assign w_sel_flag = (r_state == ST_ARP) ? arp_decode_valid : ip_valid;
  assign w_err      = crc_err & ~r_crc_base;
  assign w_len_full = r_cap - CAP_W'(ETH_FCS_BYTES);
  assign w_len_sat  = w_len_full[CAP_W-1] ? '1 : w_len_full[LEN_W-1:0];

  byte_delay #(
    .DEPTH (DEPTH),
    .CW    (DCW)
  ) u_line (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (rxd),
    .o_dout  (w_line_dout),
    .o_count (w_line_count)
  );

  // Next-state and per-cycle datapath controls.
  // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_flush     = 1'b0;
    w_start     = 1'b0;
    w_emit      = 1'b0;
    w_emit_last = 1'b0;
    w_inc_ok    = 1'b0;
    w_inc_crc   = 1'b0;
    w_inc_drop  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Only a rising flag starts a frame, so a frame already in flight is skipped.
        if (w_any_flag && !r_flag_q) begin
          if (arp_decode_valid && !ip_valid && arp_en) begin
            w_state_nxt = ST_ARP;
            w_push      = 1'b1;
            w_start     = 1'b1;
          end else if (ip_valid && !arp_decode_valid && ip_en) begin
            w_state_nxt = ST_IP;
            w_push      = 1'b1;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = ST_DROP;
            w_inc_drop  = 1'b1;
          end
        end
      end
      ST_ARP, ST_IP: begin
        if (!w_sel_flag || !busy) begin
          w_flush     = 1'b1;
          w_state_nxt = ST_IDLE;
          if (r_cap > CAP_W'(DEPTH)) begin
            w_pop       = 1'b1;
            w_emit      = 1'b1;
            w_emit_last = 1'b1;
            w_inc_crc   = w_err;
            w_inc_ok    = ~w_err;
          end else begin
            w_inc_drop  = 1'b1;
          end
        end else begin
          w_push = 1'b1;
          if (w_line_count == DCW'(DEPTH)) begin
            w_pop  = 1'b1;
            w_emit = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (!w_any_flag) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM, frame bookkeeping and registered output stage.
  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_flag_q   <= 1'b1;
      r_crc_base <= 1'b0;
      r_cap      <= '0;
      r_data     <= '0;
      r_arp_v    <= 1'b0;
      r_ip_v     <= 1'b0;
      r_last     <= 1'b0;
      r_err      <= 1'b0;
      r_len      <= '0;
      r_sa       <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_flag_q <= w_any_flag;
      r_arp_v  <= w_emit && (r_state == ST_ARP);
      r_ip_v   <= w_emit && (r_state == ST_IP);
      r_last   <= w_emit_last;
      r_err    <= w_emit_last & w_err;
      if (w_emit) r_data <= w_line_dout;
      if (w_start) begin
        r_sa       <= sa;
        r_crc_base <= crc_err;
        r_cap      <= CAP_W'(1);
      end else if (w_push && r_cap != '1) begin
        r_cap <= r_cap + 1'b1;
      end
      if (w_emit_last) r_len <= w_len_sat;
    end
  end

  // Saturating statistics counters; a clear pulse overrides any increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt_ok   <= '0;
      r_cnt_crc  <= '0;
      r_cnt_drop <= '0;
    end else if (stat_clr) begin
      r_cnt_ok   <= '0;
      r_cnt_crc  <= '0;
      r_cnt_drop <= '0;
    end else begin
      if (w_inc_ok   && r_cnt_ok   != '1) r_cnt_ok   <= r_cnt_ok   + 1'b1;
      if (w_inc_crc  && r_cnt_crc  != '1) r_cnt_crc  <= r_cnt_crc  + 1'b1;
      if (w_inc_drop && r_cnt_drop != '1) r_cnt_drop <= r_cnt_drop + 1'b1;
    end
  end

  // The idle channel shows zero data as well as zero strobes.
  assign arp_data   = r_arp_v ? r_data : '0;
  assign ip_data    = r_ip_v  ? r_data : '0;
  assign arp_valid  = r_arp_v;
  assign ip_valid_o = r_ip_v;
  assign arp_last   = r_arp_v & r_last;
  assign ip_last    = r_ip_v  & r_last;
  assign arp_err    = r_arp_v & r_err;
  assign ip_err     = r_ip_v  & r_err;
  assign frame_len  = r_len;
  assign frame_sa   = r_sa;
  assign cnt_ok     = r_cnt_ok;
  assign cnt_crc    = r_cnt_crc;
  assign cnt_drop   = r_cnt_drop;

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// Directed bench for eth_rx_dispatch. Counter and length widths are narrowed so
// saturation is reachable in a short run.
module tb_eth_rx_dispatch;

  localparam int              CNT_W   = 4;
  localparam int              LEN_W   = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int              LEN_MAX = (1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       rxd;
  logic             busy, crc_err, arp_decode_valid, ip_valid;
  logic [47:0]      sa;
  logic             arp_en, ip_en, stat_clr;
  logic [7:0]       arp_data, ip_data;
  logic             arp_valid, ip_valid_o, arp_last, ip_last, arp_err, ip_err;
  logic [LEN_W-1:0] frame_len;
  logic [47:0]      frame_sa;
  logic [CNT_W-1:0] cnt_ok, cnt_crc, cnt_drop;

  int               n_checks = 0;
  int               n_errors = 0;
  logic [CNT_W-1:0] exp_ok   = '0;
  logic [CNT_W-1:0] exp_crc  = '0;
  logic [CNT_W-1:0] exp_drop = '0;
  logic [47:0]      exp_sa   = '0;

  always #5 clk = ~clk;

  eth_rx_dispatch #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .rxd              (rxd),
    .busy             (busy),
    .crc_err          (crc_err),
    .arp_decode_valid (arp_decode_valid),
    .ip_valid         (ip_valid),
    .sa               (sa),
    .arp_en           (arp_en),
    .ip_en            (ip_en),
    .stat_clr         (stat_clr),
    .arp_data         (arp_data),
    .ip_data          (ip_data),
    .arp_valid        (arp_valid),
    .ip_valid_o       (ip_valid_o),
    .arp_last         (arp_last),
    .ip_last          (ip_last),
    .arp_err          (arp_err),
    .ip_err           (ip_err),
    .frame_len        (frame_len),
    .frame_sa         (frame_sa),
    .cnt_ok           (cnt_ok),
    .cnt_crc          (cnt_crc),
    .cnt_drop         (cnt_drop)
  );

  function automatic logic [7:0] pay_byte(input bit is_ip, input int k);
    logic [7:0] v;
    v = 8'(k);
    return is_ip ? (v * 8'd7 + 8'd3) : v;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Drive one frame (npay payload bytes + 4 FCS) followed by 8 idle cycles and
  // compare every output cycle against the expected 5-cycle-delayed stream.
  task automatic run_frame(input bit is_ip, input int npay, input bit bad_crc,
                           input bit both, input bit clr_at_eof,
                           input logic [47:0] src, input string name);
    int   m;
    bit   accepted, emits, exp_v, exp_last;
    int   exp_len;
    logic [7:0] got_d;
    logic got_v_sel, got_v_oth, got_last, got_err;
    m        = npay + 4;
    accepted = !both && (is_ip ? ip_en : arp_en);
    emits    = accepted && (m > 5);
    exp_len  = (npay > LEN_MAX) ? LEN_MAX : npay;
    for (int k = 0; k < m + 8; k++) begin
      @(posedge clk); #1;
      arp_decode_valid = (k < m) && (!is_ip || both);
      ip_valid         = (k < m) && (is_ip || both);
      busy             = (k < m);
      rxd              = (k < npay) ? pay_byte(is_ip, k) : 8'hA0 + 8'(k);
      crc_err          = (k >= m) ? bad_crc : 1'b0;
      stat_clr         = clr_at_eof && (k == m);
      sa               = (k == 0) ? src : ~src;
      @(negedge clk);
      exp_v     = emits && (k >= 6) && (k <= npay + 5);
      exp_last  = exp_v && (k == npay + 5);
      got_v_sel = is_ip ? ip_valid_o : arp_valid;
      got_v_oth = is_ip ? arp_valid  : ip_valid_o;
      got_d     = is_ip ? ip_data    : arp_data;
      got_last  = is_ip ? ip_last    : arp_last;
      got_err   = is_ip ? ip_err     : arp_err;
      n_checks++;
      if (got_v_sel !== exp_v || got_v_oth !== 1'b0) begin
        n_errors++;
        $display("FAIL %s strobes k=%0d: got sel=%b other=%b, expected sel=%b other=0",
                 name, k, got_v_sel, got_v_oth, exp_v);
      end
      if (exp_v) begin
        n_checks++;
        if (got_d !== pay_byte(is_ip, k - 6) || got_last !== exp_last) begin
          n_errors++;
          $display("FAIL %s data k=%0d: got %h last=%b, expected %h last=%b",
                   name, k, got_d, got_last, pay_byte(is_ip, k - 6), exp_last);
        end
      end
      if (exp_last) begin
        n_checks++;
        if (got_err !== bad_crc || frame_len !== LEN_W'(exp_len)) begin
          n_errors++;
          $display("FAIL %s eof: got err=%b len=%0d, expected err=%b len=%0d",
                   name, got_err, frame_len, bad_crc, exp_len);
        end
      end
    end
    crc_err  = 1'b0;
    stat_clr = 1'b0;
    if (!accepted || !emits) exp_drop = sat_inc(exp_drop);
    else if (bad_crc)        exp_crc  = sat_inc(exp_crc);
    else                     exp_ok   = sat_inc(exp_ok);
    if (accepted) exp_sa = src;
    if (clr_at_eof) begin
      exp_ok = '0; exp_crc = '0; exp_drop = '0;
    end
    n_checks++;
    if (cnt_ok !== exp_ok || cnt_crc !== exp_crc || cnt_drop !== exp_drop) begin
      n_errors++;
      $display("FAIL %s counters: got ok=%0d crc=%0d drop=%0d, expected ok=%0d crc=%0d drop=%0d",
               name, cnt_ok, cnt_crc, cnt_drop, exp_ok, exp_crc, exp_drop);
    end
    n_checks++;
    if (frame_sa !== exp_sa) begin
      n_errors++;
      $display("FAIL %s frame_sa: got %h, expected %h", name, frame_sa, exp_sa);
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({arp_data, ip_data, arp_valid, ip_valid_o, arp_last, ip_last, arp_err, ip_err,
         frame_len, frame_sa, cnt_ok, cnt_crc, cnt_drop} !== '0) begin
      n_errors++;
      $display("FAIL reset_state: outputs not all zero (ok=%0d drop=%0d sa=%h)", cnt_ok, cnt_drop, frame_sa);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_arp_good();
    run_frame(1'b0, 28, 1'b0, 1'b0, 1'b0, 48'h0200_0000_0001, "arp_good");
  endtask

  task automatic test_ip_crc();
    run_frame(1'b1, 46, 1'b1, 1'b0, 1'b0, 48'h0200_0000_0002, "ip_crc");
  endtask

  task automatic test_ip_disabled();
    ip_en = 1'b0;
    run_frame(1'b1, 30, 1'b0, 1'b0, 1'b0, 48'h0200_0000_0003, "ip_disabled");
    run_frame(1'b0, 10, 1'b0, 1'b0, 1'b0, 48'h0200_0000_0004, "arp_after_drop");
    ip_en = 1'b1;
  endtask

  task automatic test_both_flags();
    run_frame(1'b0, 12, 1'b0, 1'b1, 1'b0, 48'h0200_0000_0005, "both_flags");
  endtask

  task automatic test_runt();
    run_frame(1'b1, 1, 1'b0, 1'b0, 1'b0, 48'h0200_0000_0006, "runt_5");
    run_frame(1'b1, 2, 1'b0, 1'b0, 1'b0, 48'h0200_0000_0007, "min_6");
  endtask

  task automatic test_len_sat();
    run_frame(1'b1, 70, 1'b0, 1'b0, 1'b0, 48'h0200_0000_0008, "len_sat");
  endtask

  task automatic test_cnt_sat();
    while (exp_ok != CNT_MAX) begin
      run_frame(1'b0, 2, 1'b0, 1'b0, 1'b0, 48'h0200_0000_0009, "ok_fill");
    end
    run_frame(1'b0, 3, 1'b0, 1'b0, 1'b0, 48'h0200_0000_000A, "ok_saturate");
    run_frame(1'b1, 4, 1'b0, 1'b0, 1'b1, 48'h0200_0000_000B, "clr_wins");
  endtask

  task automatic test_reset_mid_frame();
    int m;
    m = 24;
    for (int k = 0; k < m + 8; k++) begin
      @(posedge clk); #1;
      arp_decode_valid = 1'b0;
      ip_valid         = (k < m);
      busy             = (k < m);
      rxd              = (k < 20) ? pay_byte(1'b1, k) : 8'hA0 + 8'(k);
      sa               = 48'h0A0B_0C0D_0E0F;
      if (k == 10) begin
        n_checks++;
        if (ip_valid_o !== 1'b1 || ip_data !== pay_byte(1'b1, 4)) begin
          n_errors++;
          $display("FAIL rst_pre: got valid=%b data=%h, expected valid=1 data=%h",
                   ip_valid_o, ip_data, pay_byte(1'b1, 4));
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({arp_data, ip_data, arp_valid, ip_valid_o, arp_last, ip_last, arp_err, ip_err,
             frame_len, frame_sa, cnt_ok, cnt_crc, cnt_drop} !== '0) begin
          n_errors++;
          $display("FAIL rst_async: outputs not cleared (valid=%b data=%h ok=%0d)", ip_valid_o, ip_data, cnt_ok);
        end
      end
      if (k == 12) rst = 1'b1;
      @(negedge clk);
      if (k > 10) begin
        n_checks++;
        if ({arp_valid, ip_valid_o, ip_last} !== 3'b000) begin
          n_errors++;
          $display("FAIL rst_after k=%0d: got arp_v=%b ip_v=%b ip_last=%b, expected 000",
                   k, arp_valid, ip_valid_o, ip_last);
        end
      end
    end
    exp_ok = '0; exp_crc = '0; exp_drop = '0; exp_sa = '0;
    n_checks++;
    if (cnt_ok !== exp_ok || cnt_crc !== exp_crc || cnt_drop !== exp_drop || frame_sa !== exp_sa) begin
      n_errors++;
      $display("FAIL rst_counters: got ok=%0d crc=%0d drop=%0d sa=%h, expected zeros",
               cnt_ok, cnt_crc, cnt_drop, frame_sa);
    end
    run_frame(1'b0, 8, 1'b0, 1'b0, 1'b0, 48'h0200_0000_000C, "post_reset");
  endtask

  initial begin
    rst = 1'b0;
    rxd = '0; busy = 1'b0; crc_err = 1'b0;
    arp_decode_valid = 1'b0; ip_valid = 1'b0;
    sa = '0; arp_en = 1'b1; ip_en = 1'b1; stat_clr = 1'b0;
    test_reset();
    test_arp_good();
    test_ip_crc();
    test_ip_disabled();
    test_both_flags();
    test_runt();
    test_len_sat();
    test_cnt_sat();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
